// File: rtl/hazzo.sv
// Load-use hazard detector for a 5-stage pipeline: stalls PC and IF/ID and bubbles ID/EX
// when decode reads a register that the load currently in EX is about to write.
module hazzo (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifid_memread,
  input  logic [4:0]  idex_dest,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  output logic        hazard,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        hazard_q,
  output logic [15:0] stall_cnt
);

  logic        w_dest_nz;
  logic        w_rs_match;
  logic        w_rt_match;
  logic        w_hazard;
  logic        w_cnt_sat;
  logic        r_hazard_q;
  logic [15:0] r_stall_cnt;

  // r0 is hardwired to zero, so a load targeting it can never feed a consumer.
  assign w_dest_nz  = (idex_dest != 5'd0);
  assign w_rs_match = (idex_dest == ifid_rs);
  assign w_rt_match = (idex_dest == ifid_rt);
  assign w_hazard   = ~rst & ifid_memread & w_dest_nz & (w_rs_match | w_rt_match);
  assign w_cnt_sat  = (r_stall_cnt == 16'hFFFF);

  assign hazard      = w_hazard;
  assign pc_write    = ~w_hazard;
  assign ifid_write  = ~w_hazard;
  assign idex_bubble = w_hazard;
  assign hazard_q    = r_hazard_q;
  assign stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hazard_q  <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_hazard_q <= w_hazard;
      if (w_hazard && !w_cnt_sat) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazzo.sv
// Directed bench for hazzo: a behavioural model checked every cycle plus literal pins.
module tb_hazzo;

  logic        clk;
  logic        rst;
  logic        ifid_memread;
  logic [4:0]  idex_dest;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        hazard;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic        hazard_q;
  logic [15:0] stall_cnt;

  int total;
  int bad;

  // model state
  bit m_valid;
  bit m_hq;
  int m_cnt;

  hazzo dut (
    .clk          (clk),
    .rst          (rst),
    .ifid_memread (ifid_memread),
    .idex_dest    (idex_dest),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .hazard       (hazard),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_bubble  (idex_bubble),
    .hazard_q     (hazard_q),
    .stall_cnt    (stall_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_hazard();
    if (rst) return 1'b0;
    if (!ifid_memread) return 1'b0;
    if (idex_dest == 5'd0) return 1'b0;
    return (idex_dest == ifid_rs) || (idex_dest == ifid_rt);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_hq    <= 1'b0;
      m_cnt   <= 0;
    end else if (m_valid) begin
      m_hq <= model_hazard();
      if (model_hazard()) m_cnt <= (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    cmp("hazard",      int'(hazard),      int'(model_hazard()));
    cmp("pc_write",    int'(pc_write),    int'(!model_hazard()));
    cmp("ifid_write",  int'(ifid_write),  int'(!model_hazard()));
    cmp("idex_bubble", int'(idex_bubble), int'(model_hazard()));
    if (m_valid) begin
      cmp("hazard_q",  int'(hazard_q),  int'(m_hq));
      cmp("stall_cnt", int'(stall_cnt), m_cnt);
    end
  end

  // driver: change inputs just after the active edge, then wait for the sampling edge
  task automatic apply(input bit r, input bit mr, input logic [4:0] d,
                       input logic [4:0] s, input logic [4:0] t);
    @(posedge clk);
    #1;
    rst          = r;
    ifid_memread = mr;
    idex_dest    = d;
    ifid_rs      = s;
    ifid_rt      = t;
    @(negedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_valid = 1'b0;
    m_hq    = 1'b0;
    m_cnt   = 0;
    rst = 1'b1;
    ifid_memread = 1'b0;
    idex_dest = 5'd0;
    ifid_rs = 5'd0;
    ifid_rt = 5'd0;
    repeat (2) @(posedge clk);

    // reset state
    apply(0, 0, 5'd0, 5'd0, 5'd0);
    cmp("lit_rst_cnt", int'(stall_cnt), 0);
    cmp("lit_rst_hq",  int'(hazard_q),  0);

    // no load -> no hazard
    apply(0, 0, 5'd4, 5'd4, 5'd8);
    cmp("lit_nold_haz", int'(hazard), 0);
    cmp("lit_nold_pc",  int'(pc_write), 1);
    cmp("lit_nold_if",  int'(ifid_write), 1);
    cmp("lit_nold_bub", int'(idex_bubble), 0);

    // rs match
    apply(0, 1, 5'd4, 5'd4, 5'd8);
    cmp("lit_rs_haz", int'(hazard), 1);
    cmp("lit_rs_pc",  int'(pc_write), 0);
    cmp("lit_rs_if",  int'(ifid_write), 0);
    cmp("lit_rs_bub", int'(idex_bubble), 1);
    apply(0, 0, 5'd0, 5'd0, 5'd0);
    cmp("lit_rs_hq",  int'(hazard_q), 1);
    cmp("lit_rs_cnt", int'(stall_cnt), 1);

    // rt match, then non-matching dest
    apply(0, 1, 5'd8, 5'd4, 5'd8);
    cmp("lit_rt_haz", int'(hazard), 1);
    apply(0, 1, 5'd3, 5'd4, 5'd8);
    cmp("lit_nm_haz", int'(hazard), 0);
    cmp("lit_nm_cnt", int'(stall_cnt), 2);

    // r0 never hazards; counter holds
    apply(0, 1, 5'd0, 5'd0, 5'd0);
    cmp("lit_r0_haz", int'(hazard), 0);
    apply(0, 1, 5'd0, 5'd0, 5'd0);
    cmp("lit_r0_cnt", int'(stall_cnt), 2);

    // both fields match
    apply(0, 1, 5'd31, 5'd31, 5'd31);
    cmp("lit_both_haz", int'(hazard), 1);
    apply(0, 0, 5'd31, 5'd31, 5'd31);
    cmp("lit_both_cnt", int'(stall_cnt), 3);

    // three-edge stall after reset, then reset mid-stall
    apply(1, 0, 5'd0, 5'd0, 5'd0);
    apply(0, 1, 5'd5, 5'd5, 5'd0);
    apply(0, 1, 5'd5, 5'd5, 5'd0);
    apply(0, 1, 5'd5, 5'd0, 5'd5);
    apply(0, 0, 5'd5, 5'd5, 5'd0);
    cmp("lit_three_cnt", int'(stall_cnt), 3);
    apply(0, 1, 5'd5, 5'd5, 5'd0);
    apply(1, 1, 5'd5, 5'd5, 5'd0);
    cmp("lit_midrst_haz", int'(hazard), 0);
    cmp("lit_midrst_bub", int'(idex_bubble), 0);
    cmp("lit_midrst_pc",  int'(pc_write), 1);
    apply(0, 0, 5'd0, 5'd0, 5'd0);
    cmp("lit_midrst_cnt", int'(stall_cnt), 0);
    cmp("lit_midrst_hq",  int'(hazard_q), 0);

    // saturation: drive 65534 hazard edges to reach 16'hFFFE
    apply(0, 1, 5'd9, 5'd9, 5'd1);
    repeat (65533) @(posedge clk);
    apply(0, 0, 5'd9, 5'd9, 5'd1);
    cmp("lit_fffe", int'(stall_cnt), 16'hFFFE);
    apply(0, 1, 5'd9, 5'd1, 5'd9);
    apply(0, 1, 5'd9, 5'd1, 5'd9);
    apply(0, 1, 5'd9, 5'd1, 5'd9);
    apply(0, 1, 5'd9, 5'd1, 5'd9);
    cmp("lit_sat", int'(stall_cnt), 16'hFFFF);
    apply(0, 0, 5'd0, 5'd0, 5'd0);
    cmp("lit_sat_hold", int'(stall_cnt), 16'hFFFF);

    // reset priority over a simultaneous hazard
    apply(1, 1, 5'd7, 5'd7, 5'd7);
    apply(0, 0, 5'd7, 5'd7, 5'd7);
    cmp("lit_prio_cnt", int'(stall_cnt), 0);

    // a few random-field vectors for the model
    for (int i = 0; i < 40; i++) begin
      apply(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazzo.md
HAZZO -- requirements
Module: hazzo

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled only on rising edge of clk.
REQ-003 ifid_memread  input  1  high when the instruction one stage ahead of decode (in EX) is a load.
REQ-004 idex_dest  input  5  destination register number of that instruction; a narrower driven value is zero-extended.
REQ-005 ifid_rs  input  5  source register rs of the instruction in decode.
REQ-006 ifid_rt  input  5  source register rt of the instruction in decode.
REQ-007 hazard  output  1  load-use hazard detected this cycle; combinational.
REQ-008 pc_write  output  1  PC update enable; combinational, equals NOT hazard.
REQ-009 ifid_write  output  1  IF/ID register write enable; combinational, equals NOT hazard.
REQ-010 idex_bubble  output  1  zero control signals into ID/EX (insert NOP); combinational, equals hazard.
REQ-011 hazard_q  output  1  hazard registered one cycle (previous-cycle stall indicator).
REQ-012 stall_cnt  output  16  number of cycles with hazard=1 since reset, saturating.

Function
REQ-013 hazard SHALL be 1 iff all of the following hold:
- rst=0
- ifid_memread=1
- idex_dest != 0
- idex_dest == ifid_rs, or idex_dest == ifid_rt
REQ-014 Register 0 SHALL never cause a hazard (idex_dest=0 gives hazard=0 even if rs or rt is 0).
REQ-015 A match on rs, on rt, or on both SHALL all yield hazard=1; there is no double counting.
REQ-016 hazard SHALL be 0 whenever ifid_memread=0, regardless of register fields.
REQ-017 hazard, pc_write, ifid_write and idex_bubble SHALL have zero-cycle latency from inputs (purely combinational, no clock dependence).
REQ-018 While rst=1: hazard=0, pc_write=1, ifid_write=1, idex_bubble=0.
REQ-019 hazard_q SHALL load the hazard value at each rising edge with rst=0.
REQ-020 stall_cnt SHALL increment by 1 at each rising edge where rst=0 and hazard=1.
REQ-021 stall_cnt SHALL hold at 16'hFFFF once reached; no wrap-around.
REQ-022 Consecutive hazard cycles SHALL each stall independently; the block holds no FSM and makes no assumption about how long a stall lasts.
REQ-023 No output SHALL be X when all inputs are known; unknown inputs are out of scope.

Reset
REQ-024 On a rising edge with rst=1: hazard_q <= 0, stall_cnt <= 0.
REQ-025 Reset SHALL take priority over a simultaneous hazard (no increment on a reset edge).
REQ-026 Reset asserted mid-stall SHALL:
- deassert hazard and idex_bubble immediately (combinational);
- clear the registers at the next edge.
REQ-027 Sequential outputs SHALL be undefined before the first reset edge; the bench applies rst=1 for at least 1 cycle.

Verification
REQ-028 memread=0, dest=5'd4, rs=5'd4, rt=5'd8 -> hazard=0, pc_write=1, ifid_write=1, idex_bubble=0.
REQ-029 memread=1, dest=5'd4, rs=5'd4, rt=5'd8 -> hazard=1, pc_write=0, ifid_write=0, idex_bubble=1; hazard_q=1 and stall_cnt=1 after the next edge.
REQ-030 memread=1, dest=5'd8, rs=5'd4, rt=5'd8 -> hazard=1 (rt match); with dest=5'd3 instead -> hazard=0.
REQ-031 memread=1, dest=0, rs=0, rt=0 -> hazard=0; stall_cnt unchanged.
REQ-032 Hazard held for 3 edges -> stall_cnt=3; then rst=1 for 1 edge -> stall_cnt=0, hazard_q=0, and hazard=0 during reset.
REQ-033 Force stall_cnt to 16'hFFFE, hold hazard for 3 edges -> stall_cnt=16'hFFFF and stays there.
